// File: rtl/uart_rx.sv
// UART receiver: oversampled 8N1 framing with a valid/ready holding register.
// Framing errors and overruns are reported as one-clk pulses.
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 baud_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_END  = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t               state;
  logic                 rx_m;
  logic                 rx_s;
  logic [TW-1:0]        tick_cnt;
  logic [BW-1:0]        bit_cnt;
  logic [DATA_BITS-1:0] shreg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
      if (baud_tick) begin
        unique case (state)
          IDLE: begin
            if (!rx_s) begin
              state    <= START;
              tick_cnt <= '0;
            end
          end
          START: begin
            if (tick_cnt == T_MID) begin
              tick_cnt <= '0;
              bit_cnt  <= '0;
              state    <= rx_s ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          DATA: begin
            if (tick_cnt == T_END) begin
              shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
              tick_cnt <= '0;
              bit_cnt  <= bit_cnt + 1'b1;
              if (bit_cnt == B_LAST) begin
                state <= STOP;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          STOP: begin
            if (tick_cnt == T_END) begin
              tick_cnt <= '0;
              if (rx_s) begin
                state <= IDLE;
                // An accept on this same edge frees the slot for the new byte.
                if (!rx_valid || rx_ready) begin
                  rx_data  <= shreg;
                  rx_valid <= 1'b1;
                end else begin
                  overrun <= 1'b1;
                end
              end else begin
                frame_err <= 1'b1;
                state     <= WAIT_IDLE;
              end
            end else begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          WAIT_IDLE: begin
            if (rx_s) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomized checks of uart_rx framing, handshake and errors.
// Frames are built from byte values; received bytes are compared in order.
module tb_uart_rx;

  localparam int BIT_CLK = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       baud_tick = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic       frame_err;
  logic       overrun;

  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_ferr = 0;
  int n_ovr = 0;
  int n_rise = 0;
  int rise_cyc = 0;
  int t0 = 0;
  logic rise_tick = 1'b0;
  logic prev_valid = 1'b0;
  logic prev_tick = 1'b0;
  logic [7:0] got[$];
  logic [7:0] exp_q[$];

  uart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .baud_tick(baud_tick),
    .rx(rx),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .frame_err(frame_err),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  initial begin
    int tc;
    tc = 0;
    forever begin
      @(posedge clk);
      #1;
      tc = (tc + 1) % 4;
      baud_tick = (tc == 0);
    end
  end

  always @(negedge clk) begin
    cyc++;
    if (rx_valid && rx_ready) got.push_back(rx_data);
    if (frame_err) n_ferr++;
    if (overrun) n_ovr++;
    if (rx_valid && !prev_valid) begin
      n_rise++;
      rise_cyc = cyc;
      rise_tick = prev_tick;
    end
    prev_valid = rx_valid;
    prev_tick = baud_tick;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    step(BIT_CLK);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    t0 = cyc;
    for (int i = 0; i < 10; i++) drive_bit(f[i]);
    rx = 1'b1;
  endtask

  initial begin
    int f0, o0, r0, d;
    logic [7:0] b;
    step(3);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    rst_n = 1'b1;
    step(BIT_CLK);

    // single good frame
    got.delete();
    f0 = n_ferr; o0 = n_ovr;
    send_frame(8'hA5, 1'b1);
    step(BIT_CLK);
    chk("a5_count", got.size(), 1);
    if (got.size() > 0) chk("a5_data", got[0], 8'hA5);
    chk("a5_ferr", n_ferr - f0, 0);
    chk("a5_ovr", n_ovr - o0, 0);
    d = rise_cyc - t0;
    chk("a5_lat_win", (d >= 9 * BIT_CLK && d <= 10 * BIT_CLK), 1);
    chk("a5_lat_tick", rise_tick, 1);

    // false start
    r0 = n_rise; f0 = n_ferr;
    rx = 1'b0;
    step(24);
    rx = 1'b1;
    step(3 * BIT_CLK);
    chk("glitch_valid", n_rise - r0, 0);
    chk("glitch_ferr", n_ferr - f0, 0);

    // line break
    got.delete();
    r0 = n_rise; f0 = n_ferr;
    send_frame(8'h3C, 1'b0);
    rx = 1'b0;
    step(40 * BIT_CLK);
    chk("brk_ferr", n_ferr - f0, 1);
    chk("brk_valid", n_rise - r0, 0);
    rx = 1'b1;
    step(2 * BIT_CLK);
    send_frame(8'h81, 1'b1);
    step(BIT_CLK);
    chk("brk_count", got.size(), 1);
    if (got.size() > 0) chk("brk_81", got[0], 8'h81);

    // overrun while holding
    got.delete();
    o0 = n_ovr;
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    step(BIT_CLK);
    chk("ovr_valid", rx_valid, 1);
    chk("ovr_data", rx_data, 8'h11);
    chk("ovr_pulse", n_ovr - o0, 1);
    rx_ready = 1'b1;
    step(1);
    chk("ovr_drop", rx_valid, 0);
    chk("ovr_keep", rx_data, 8'h11);
    chk("ovr_got", got.size(), 1);

    // reset mid-frame
    got.delete();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1);
    step(BIT_CLK / 2);
    rst_n = 1'b0;
    rx = 1'b1;
    step(2);
    chk("mrst_valid", rx_valid, 0);
    chk("mrst_data", rx_data, 0);
    chk("mrst_ferr", frame_err, 0);
    chk("mrst_ovr", overrun, 0);
    rst_n = 1'b1;
    step(BIT_CLK);
    send_frame(8'h5A, 1'b1);
    step(BIT_CLK);
    chk("mrst_count", got.size(), 1);
    if (got.size() > 0) chk("mrst_5a", got[0], 8'h5A);

    // back-to-back with pulsed ready
    got.delete();
    f0 = n_ferr; o0 = n_ovr;
    rx_ready = 1'b0;
    fork
      begin
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h55, 1'b1);
      end
      begin
        for (int k = 0; k < 3; k++) begin
          for (int w = 0; w < 2000 && !rx_valid; w++) step(1);
          chk("b2b_wait", rx_valid, 1);
          rx_ready = 1'b1;
          step(1);
          rx_ready = 1'b0;
        end
      end
    join
    step(BIT_CLK);
    exp_q = '{8'h00, 8'hFF, 8'h55};
    chk("b2b_count", got.size(), 3);
    for (int i = 0; i < 3 && i < got.size(); i++)
      chk($sformatf("b2b_%0d", i), got[i], exp_q[i]);
    chk("b2b_ovr", n_ovr - o0, 0);
    chk("b2b_ferr", n_ferr - f0, 0);

    // randomized bytes and idle gaps
    got.delete();
    exp_q.delete();
    f0 = n_ferr; o0 = n_ovr;
    rx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      b = 8'($urandom);
      exp_q.push_back(b);
      send_frame(b, 1'b1);
      step($urandom_range(0, 3) * BIT_CLK);
    end
    step(BIT_CLK);
    chk("rnd_count", got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++)
      chk($sformatf("rnd_%0d", i), got[i], exp_q[i]);
    chk("rnd_ovr", n_ovr - o0, 0);
    chk("rnd_ferr", n_ferr - f0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
